// File: rtl/ca_pkg.sv
// Shared constants and FSM state type for the GF(2) 7-by-4 polynomial divider.
// Bit i of every polynomial vector holds the coefficient of x^i.
package ca_pkg;
  localparam int A_W = 7;   // dividend width
  localparam int B_W = 4;   // divisor width
  localparam int Q_W = 7;   // quotient width
  localparam int R_W = 3;   // remainder width (deg r < deg b <= 3)
  localparam int K_W = 3;   // step index width, k = 6..0
  localparam int D_W = 2;   // divisor degree width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/gf2_deg4.sv
// Degree of a 4-bit GF(2) polynomial.
// Ports:
//   p    : polynomial, bit i = coeff of x^i
//   deg  : index of the highest set bit (0 when p == 0)
//   zero : p is the zero polynomial
import ca_pkg::*;

module gf2_deg4 (
  input  logic [B_W-1:0] p,
  output logic [D_W-1:0] deg,
  output logic           zero
);
  always_comb begin
    deg  = 2'd0;
    zero = 1'b0;
    if      (p[3]) deg = 2'd3;
    else if (p[2]) deg = 2'd2;
    else if (p[1]) deg = 2'd1;
    else if (p[0]) deg = 2'd0;
    else           zero = 1'b1;
  end
endmodule

// File: rtl/ca_div_7by4.sv
// Sequential carry-less (GF(2)) divider: a = clmul(q, b) ^ r, deg r < deg b.
// One conditional shift-XOR per cycle, dividend bits scanned from x^6 down
// to x^0, so a result appears a fixed 8 cycles after acceptance.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready, a, b : operand handshake (accepted only when idle)
//   out_valid/out_ready   : result handshake, outputs held under backpressure
//   q, r, div0            : quotient, remainder, divide-by-zero flag
import ca_pkg::*;

module ca_div_7by4 (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] q,
  output logic [R_W-1:0] r,
  output logic           div0
);
  state_e         state_q, state_d;
  logic [A_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0] quo_q, quo_d;
  logic [B_W-1:0] b_q, b_d;
  logic [D_W-1:0] deg_q, deg_d;
  logic           zero_q, zero_d;
  logic [K_W-1:0] k_q, k_d;
  logic [Q_W-1:0] q_q, q_d;
  logic [R_W-1:0] r_q, r_d;
  logic           div0_q, div0_d;

  logic [D_W-1:0] in_deg;
  logic           in_zero;

  gf2_deg4 u_deg (
    .p    (b),
    .deg  (in_deg),
    .zero (in_zero)
  );

  // Single division step at index k_q.
  logic [K_W-1:0] shift;
  logic [A_W-1:0] rem_step;
  logic [Q_W-1:0] quo_step;

  always_comb begin
    shift    = k_q - {1'b0, deg_q};
    rem_step = rem_q;
    quo_step = quo_q;
    // Reduce only when the leading term of rem sits at or above deg(b).
    // A zero divisor never reduces; its result is forced to zero at the end.
    if (!zero_q && (k_q >= {1'b0, deg_q}) && rem_q[k_q]) begin
      rem_step        = rem_q ^ ({{(A_W-B_W){1'b0}}, b_q} << shift);
      quo_step[shift] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    b_d     = b_q;
    deg_d   = deg_q;
    zero_d  = zero_q;
    k_d     = k_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          rem_d   = a;
          quo_d   = '0;
          b_d     = b;
          deg_d   = in_deg;
          zero_d  = in_zero;
          k_d     = K_W'(A_W - 1);
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (k_q == '0) begin
          state_d = DONE;
          // All bits at or above deg(b) are cleared by now, so the low three
          // bits are the full remainder.
          q_d     = zero_q ? '0 : quo_step;
          r_d     = zero_q ? '0 : rem_step[R_W-1:0];
          div0_d  = zero_q;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      deg_q   <= '0;
      zero_q  <= 1'b0;
      k_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      deg_q   <= deg_d;
      zero_q  <= zero_d;
      k_q     <= k_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign div0      = div0_q;
endmodule

// File: tb/tb_ca_div_7by4.sv
module tb_ca_div_7by4;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] q;
  logic [2:0] r;
  logic       div0;

  ca_div_7by4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] q;
    logic [2:0] r;
    logic       div0;
  } res_t;

  res_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Brute-force reference: the unique q with deg(a ^ clmul(q,b)) < deg(b).
  function automatic res_t model(input logic [6:0] aa, input logic [3:0] bb);
    res_t res;
    int   db;
    logic [9:0] prod;
    res = '0;
    if (bb == 4'd0) begin
      res.div0 = 1'b1;
      return res;
    end
    db = 0;
    for (int i = 0; i < 4; i++) if (bb[i]) db = i;
    for (int qq = 0; qq < 128; qq++) begin
      prod = '0;
      for (int i = 0; i < 7; i++)
        if (qq[i]) prod = prod ^ ({6'd0, bb} << i);
      prod = prod ^ {3'd0, aa};
      if ((prod >> db) == 10'd0) begin
        res.q = qq[6:0];
        res.r = prod[2:0];
        return res;
      end
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 7'd0 || r !== 3'd0 || div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%b r=%b div0=%b, want 1 0 0 0 0",
               in_ready, out_valid, q, r, div0);
    end
  endtask

  // Issue one operation, wait for the result, apply hold cycles of backpressure,
  // then take it and check the scoreboard.
  task automatic run_op(input logic [6:0] aa, input logic [3:0] bb, input int hold);
    int   cyc;
    res_t exp;
    res_t snap;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL ready_wait: in_ready=%b, want 1", in_ready);
    end
    in_valid = 1'b1; a = aa; b = bb;
    exp_q.push_back(model(aa, bb));
    tick();                                   // E0
    in_valid = 1'b0; a = '0; b = '0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    vectors++;
    if (cyc !== 7) begin
      miscompares++;
      $display("FAIL latency a=%b b=%b: %0d edges after acceptance, want 7", aa, bb, cyc);
    end
    snap = '{q: q, r: r, div0: div0};
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = 7'h55; b = 4'h3;   // must be ignored
      tick();
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== snap.q || r !== snap.r || div0 !== snap.div0) begin
        miscompares++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b q=%b r=%b div0=%b, want 1 0 %b %b %b",
                 h, out_valid, in_ready, q, r, div0, snap.q, snap.r, snap.div0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    vectors++;
    if (q !== exp.q || r !== exp.r || div0 !== exp.div0) begin
      miscompares++;
      $display("FAIL result a=%b b=%b: q=%b r=%b div0=%b, want q=%b r=%b div0=%b",
               aa, bb, q, r, div0, exp.q, exp.r, exp.div0);
    end
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== exp.q || r !== exp.r || div0 !== exp.div0) begin
      miscompares++;
      $display("FAIL handoff: out_valid=%b in_ready=%b q=%b r=%b, want 0 1 %b %b",
               out_valid, in_ready, q, r, exp.q, exp.r);
    end
  endtask

  // Fixed vectors also cross-checked against hand-derived constants.
  task automatic test_directed();
    res_t m;
    logic [6:0] av [6];
    logic [3:0] bv [6];
    logic [10:0] ev [6];
    av = '{7'b1010101, 7'b1111111, 7'b1111111, 7'b1010101, 7'b1010101, 7'b0000011};
    bv = '{4'b1011,    4'b1011,    4'b1101,    4'b0001,    4'b0000,    4'b1011};
    ev = '{{7'b0001001, 3'b110, 1'b0}, {7'b0001101, 3'b000, 1'b0}, {7'b0001011, 3'b000, 1'b0},
           {7'b1010101, 3'b000, 1'b0}, {7'b0000000, 3'b000, 1'b1}, {7'b0000000, 3'b011, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      m = model(av[i], bv[i]);
      vectors++;
      if (m !== ev[i]) begin
        miscompares++;
        $display("FAIL model%0d: got %b, want %b", i, m, ev[i]);
      end
      run_op(av[i], bv[i], 0);
    end
  endtask

  task automatic test_backpressure();
    run_op(7'b1100110, 4'b0111, 5);
  endtask

  task automatic test_reset_mid();
    int seen;
    while (!in_ready) tick();
    in_valid = 1'b1; a = 7'b1111000; b = 4'b0101;
    tick();                                   // E0
    in_valid = 1'b0;
    tick(); tick(); tick();                   // E1..E3
    rst = 1'b1;
    tick();                                   // E4 is the reset edge
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 7'd0 || r !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b q=%b r=%b, want 1 0 0 0",
               in_ready, out_valid, q, r);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_out: out_valid high %0d cycles, want 0", seen);
    end
    run_op(7'b1101011, 4'b1011, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++)
      run_op(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), i % 3);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/ca_div_7by4.md
CA_DIV_7BY4 -- requirements
Module: ca_div_7by4

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  operand pair present on a/b.
REQ-004 SHALL have port: in_ready  output  1  block idle, can accept operands.
REQ-005 SHALL have port: a  input  7  dividend polynomial over GF(2); bit i = coeff of x^i.
REQ-006 SHALL have port: b  input  4  divisor polynomial over GF(2); bit i = coeff of x^i.
REQ-007 SHALL have port: out_valid  output  1  q/r/div0 hold a completed result.
REQ-008 SHALL have port: out_ready  input  1  consumer takes result.
REQ-009 SHALL have port: q  output  7  quotient polynomial.
REQ-010 SHALL have port: r  output  3  remainder polynomial, deg r < deg b.
REQ-011 SHALL have port: div0  output  1  set when accepted b was zero.
REQ-012 SHALL have parameters: none; widths fixed by package constants.

Function
REQ-013 SHALL compute carry-less (GF(2)) division: a = clmul(q, b) XOR r, deg r < deg b; inverse of the team's 4x4 carry-less multiplier.
REQ-014 SHALL accept operands when in_valid && in_ready at a rising edge (edge E0), registering a, b and deg(b).
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state == IDLE).
REQ-016 SHALL spend exactly 7 CALC cycles, step index k = 6 down to 0, one step per edge E1..E7.
REQ-017 SHALL at step k: if k >= deg(b) and rem[k] == 1, rem ^= (b << (k - deg(b))) and q[k - deg(b)] = 1; otherwise no change.
REQ-018 SHALL enter DONE at E7 with out_valid = 1 visible in the cycle after E7 (fixed latency 8 cycles from acceptance to out_valid high).
REQ-019 SHALL hold q, r, div0 and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL return to IDLE at the edge where out_valid && out_ready; out_valid deasserts same edge; next acceptance no earlier than following edge.
REQ-021 SHALL, for b == 0, still take the full 8-cycle latency and report div0 = 1, q = 0, r = 0.
REQ-022 SHALL, for b == 1 (deg 0), produce q = a, r = 0.
REQ-023 SHALL, when deg(a) < deg(b), produce q = 0, r = a[2:0].
REQ-024 SHALL ignore in_valid, a, b while not IDLE (no queueing).
REQ-025 SHALL keep q/r/div0 at last result values while IDLE after handshake.

Reset
REQ-026 SHALL on rst at a rising edge: state = IDLE, out_valid = 0, q = 0, r = 0, div0 = 0, internal rem/k/deg cleared.
REQ-027 SHALL on rst mid-CALC or in DONE abort the operation with no result delivered; in_ready = 1 in the cycle after the reset edge.
REQ-028 SHALL give rst priority over every handshake event at the same edge.

Structure
REQ-029 SHALL place constants A_W = 7, B_W = 4, Q_W = 7, R_W = 3 and the FSM state enum (IDLE, CALC, DONE) in shared package ca_pkg.
REQ-030 SHALL use one sub-module gf2_deg4: combinational priority encoder, 4-bit polynomial -> 2-bit degree plus zero flag.
REQ-031 SHALL keep datapath single-step (one conditional XOR per cycle); no unrolled combinational divider.

Verification
REQ-032 SHALL cover: a = 1010101, b = 1011 -> after 8 cycles out_valid = 1, q = 0001001, r = 110, div0 = 0.
REQ-033 SHALL cover round trip: a = 1111111 (clmul of 1101 and 1011), b = 1011 -> q = 0001101, r = 000; also b = 1101 -> q = 0001011, r = 000.
REQ-034 SHALL cover edge divisors: b = 0001, a = 1010101 -> q = 1010101, r = 000; b = 0000 -> div0 = 1, q = 0, r = 0, same latency.
REQ-035 SHALL cover small dividend: a = 0000011, b = 1011 -> q = 0000000, r = 011.
REQ-036 SHALL cover backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready = 0, new in_valid ignored; result taken on first out_ready = 1 edge.
REQ-037 SHALL cover reset at E4 of an operation -> out_valid never asserts for it, in_ready = 1 next cycle, following operation correct.
